// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter owning a shared WIDTH-bit q/qb flip-flop bank
// Define DFF_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others are waiting
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr_en,
    input  logic [NREQ*WIDTH-1:0]   d,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qb,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner_id
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic {IDLE, OWN} state_t;
    state_t state, state_nx;
    logic [NREQ-1:0] cand, gnt_nx;
    logic [IW-1:0] win, ptr, ptr_nx, owner_nx;
    logic [WIDTH-1:0] d_own, q_nx, qb_nx;
    logic found, own, rel, pre, wr, take, busy_nx;
    int idx;
    if (NREQ < 2 || NREQ > 16 || MAX_HOLD < 2) begin : g_bad_params
        $error("dff_bank_arbiter: NREQ must be 2..16 and MAX_HOLD >= 2");
    end
    assign own   = state == OWN;
    assign rel   = own && !req[owner_id];
    assign wr    = own && req[owner_id] && wr_en[owner_id];
    assign d_own = d[int'(owner_id)*WIDTH +: WIDTH];
    // the current owner never competes in a handoff search
    assign cand  = own ? req & ~gnt : req;
`ifdef DFF_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold, hold_nx;
    assign pre     = own && hold == HW'(MAX_HOLD - 1) && req[owner_id] && |cand;
    assign hold_nx = take ? '0 : (own && hold != HW'(MAX_HOLD - 1)) ? hold + 1'b1 : hold;
`else
    assign pre = 1'b0;
`endif
    assign take = found && (!own || rel || pre);
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && cand[IW'(idx)]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        busy_nx  = busy;
        owner_nx = owner_id;
        ptr_nx   = ptr;
        q_nx     = wr ? d_own : q;
        qb_nx    = wr ? ~d_own : qb;
        if (take) begin
            state_nx = OWN;
            gnt_nx   = NREQ'(1) << win;
            busy_nx  = 1'b1;
            owner_nx = win;
            ptr_nx   = win == IW'(NREQ - 1) ? '0 : win + 1'b1;
        end else if (rel) begin
            state_nx = IDLE;
            gnt_nx   = '0;
            busy_nx  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            owner_id <= '0;
            ptr      <= '0;
            q        <= '0;
            qb       <= '1;
`ifdef DFF_ARB_TIMEOUT_EN
            hold     <= '0;
`endif
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            busy     <= busy_nx;
            owner_id <= owner_nx;
            ptr      <= ptr_nx;
            q        <= q_nx;
            qb       <= qb_nx;
`ifdef DFF_ARB_TIMEOUT_EN
            hold     <= hold_nx;
`endif
        end
    end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit bank of D flip-flops (q/qb pair per bit) between NREQ requesters.
- A requester raises req, receives a one-hot registered grant, and then owns the bank. While it owns the bank it writes its own data slice into the bank with wr_en. Ownership ends when it drops req.
- Sits in front of the flip-flop storage and is the only path into it.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, bank width in bits.
- MAX_HOLD, 8, maximum consecutive owned cycles before preemption; used only when DFF_ARB_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NREQ  request; bit i belongs to requester i.
- wr_en  input  NREQ  write strobe; bit i belongs to requester i.
- d  input  NREQ*WIDTH  write data; requester i drives d[i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered grant; one-hot or all-zero.
- q  output  WIDTH  bank contents.
- qb  output  WIDTH  complement of q, registered alongside q.
- busy  output  1  high while a requester owns the bank.
- owner_id  output  $clog2(NREQ)  index of the current owner; holds its last value when busy=0.

Behaviour:
- Reset is synchronous and active-low, and it is the only reset. rst_n=0 sampled at a rising edge sets:
  - state=IDLE, gnt=0, busy=0, owner_id=0
  - q=0, qb=all ones
  - rotate pointer ptr=0, hold counter=0
- Reset asserted mid-ownership aborts ownership at that edge. The same-cycle wr_en is not written.
- All outputs are registered; there is no combinational path from input to output.
- Winner search: the lowest index at or after ptr with req=1, wrapping modulo NREQ. On each grant, ptr becomes winner+1 mod NREQ.
- IDLE state:
  - If any req is 1, the next edge sets gnt to the one-hot winner, sets owner_id, sets busy=1, and moves to OWN.
  - Latency from req to gnt is 1 cycle.
- OWN state, per cycle:
  - Write: if req[owner]=1 and wr_en[owner]=1, the next edge loads q <= owner's d slice and qb <= its complement.
  - No write: q and qb hold.
  - wr_en and d from non-owners are always ignored.
- Release: req[owner]=0 sampled while in OWN.
  - No write happens that cycle.
  - Next edge, with another req pending: gnt switches directly to the next winner (back-to-back handoff, no idle cycle) and busy stays 1.
  - Next edge, with nothing pending: gnt=0, busy=0, state returns to IDLE.
- gnt never has more than one bit set, including across a handoff edge.
- q and qb keep their value across ownership changes and IDLE periods.
- Hold counter:
  - Cleared on every new grant.
  - Increments each owned cycle.
  - Saturates at MAX_HOLD-1.

Optional Feature:
- Macro: DFF_ARB_TIMEOUT_EN.
- Defined: preemption when all of the following hold in one cycle:
  - hold counter = MAX_HOLD-1
  - the owner still holds req
  - at least one other req is pending
- On preemption:
  - The owner's write in that final cycle is still performed.
  - At the next edge gnt moves to the next winner, and the preempted owner is excluded from that search.
  - The preempted requester may re-win later through normal rotation.
- Defined, but no other requester pending: the owner keeps the bank indefinitely with the counter saturated.
- Not defined: there is no hold counter and no preemption; an owner keeps the bank until it drops req.

Test Plan:
- Reset mid-operation, NREQ=4, WIDTH=8, after several writes: rst_n=0 for 1 edge -> q=8'h00, qb=8'hFF, gnt=0, busy=0, owner_id=0; the next grant for all-asserted req goes to requester 0.
- Single owner writes: req=4'b0100, then wr_en[2]=1 with d slice 2 = 8'hA5 -> gnt=4'b0100 one cycle after req; q=8'hA5, qb=8'h5A one edge after wr_en; wr_en[0]=1 with slice 0 = 8'h3C at the same time has no effect.
- Round-robin order: req=4'b1111 held, each owner drops req after 2 cycles and re-raises it -> grant order 0,1,2,3,0; handoffs occur on consecutive edges with no gnt=0 cycle and busy stays 1.
- Release to idle: the sole owner 1 drops req with wr_en[1]=1 and slice 1 = 8'hFF -> no write, q keeps its prior value, gnt=0 and busy=0 next edge, owner_id stays 1.
- With DFF_ARB_TIMEOUT_EN and MAX_HOLD=4, requesters 0 and 3 hold req continuously -> owner 0 holds gnt exactly 4 cycles, then gnt=4'b1000 for 4 cycles, then back to 4'b0001.
- With DFF_ARB_TIMEOUT_EN, only requester 0 requests for 20 cycles -> gnt stays 4'b0001 throughout and no preemption occurs.
